// File: rtl/inst_fetcher.sv
// inst_fetcher: instruction fetch front end between the icache and the decoder.
// Issues one icache request at a time, presents the returned word to the
// decoder until it is issued, and discards responses made stale by a redirect.
// Optional build macro IF_PERF_CNT_EN adds the issue_cnt performance counter.
module inst_fetcher (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] next_pc,
    input  logic        issue_signal,
    input  logic        jalr_stall,
    input  logic        wrong_predicted,
    input  logic [31:0] correct_pc,
    output logic        valid,
    output logic        start_decoder,
    output logic [31:0] inst,
    output logic [31:0] inst_addr,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_ready,
    input  logic [31:0] icache_inst
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] issue_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_addr;
    logic [31:0] r_inst;
    logic [31:0] r_inst_addr;
    logic        r_valid;
    logic        r_icache_req;

    // The decoder never issues while it stalls on a JALR, so the stall only
    // shows up here through issue_signal staying low.
    logic        w_unused;
    assign w_unused = jalr_stall;

    // Fetch FSM: request / present / discard-stale-response sequencing.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state      <= ST_FETCH;
            r_pc         <= 32'd0;
            r_req_addr   <= 32'd0;
            r_inst       <= 32'd0;
            r_inst_addr  <= 32'd0;
            r_valid      <= 1'b0;
            r_icache_req <= 1'b1;
        end else if (rdy_in) begin
            case (r_state)
                ST_FETCH: begin
                    if (wrong_predicted) begin
                        r_pc <= correct_pc;
                        if (icache_ready) begin
                            // Response arrived for the squashed path: drop it
                            // and immediately request the redirect target.
                            r_req_addr <= correct_pc;
                        end else begin
                            // Request still in flight; wait for it to drain
                            // before the address may change.
                            r_state <= ST_FLUSH;
                        end
                    end else if (icache_ready) begin
                        r_inst       <= icache_inst;
                        r_inst_addr  <= r_req_addr;
                        r_valid      <= 1'b1;
                        r_icache_req <= 1'b0;
                        r_state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (wrong_predicted) begin
                        r_valid      <= 1'b0;
                        r_pc         <= correct_pc;
                        r_req_addr   <= correct_pc;
                        r_icache_req <= 1'b1;
                        r_state      <= ST_FETCH;
                    end else if (issue_signal) begin
                        r_valid      <= 1'b0;
                        r_pc         <= next_pc;
                        r_req_addr   <= next_pc;
                        r_icache_req <= 1'b1;
                        r_state      <= ST_FETCH;
                    end
                end
                ST_FLUSH: begin
                    // Latest redirect target always wins.
                    if (wrong_predicted) begin
                        r_pc <= correct_pc;
                    end
                    if (icache_ready) begin
                        r_req_addr <= wrong_predicted ? correct_pc : r_pc;
                        r_state    <= ST_FETCH;
                    end
                end
                default: begin
                    r_valid      <= 1'b0;
                    r_icache_req <= 1'b1;
                    r_state      <= ST_FETCH;
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_issue_cnt;

    // Count instructions actually accepted by the decoder (not squashed ones).
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_issue_cnt <= 32'd0;
        end else if (rdy_in && (r_state == ST_HOLD) && issue_signal && !wrong_predicted) begin
            r_issue_cnt <= r_issue_cnt + 32'd1;
        end
    end

    assign issue_cnt = r_issue_cnt;
`endif

    assign valid         = r_valid;
    assign start_decoder = r_valid;
    assign inst          = r_inst;
    assign inst_addr     = r_inst_addr;
    assign icache_req    = r_icache_req;
    assign icache_addr   = {r_req_addr[31:2], 2'b00};

endmodule

// File: tb/tb_inst_fetcher.sv
// tb_inst_fetcher: table-driven fetch/issue sequence with a response
// scoreboard, plus directed redirect, stall, freeze and reset sequences.
module tb_inst_fetcher;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] next_pc;
    logic        issue_signal;
    logic        jalr_stall;
    logic        wrong_predicted;
    logic [31:0] correct_pc;
    logic        valid;
    logic        start_decoder;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_ready;
    logic [31:0] icache_inst;
`ifdef IF_PERF_CNT_EN
    logic [31:0] issue_cnt;
`endif

    inst_fetcher dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .next_pc         (next_pc),
        .issue_signal    (issue_signal),
        .jalr_stall      (jalr_stall),
        .wrong_predicted (wrong_predicted),
        .correct_pc      (correct_pc),
        .valid           (valid),
        .start_decoder   (start_decoder),
        .inst            (inst),
        .inst_addr       (inst_addr),
        .icache_req      (icache_req),
        .icache_addr     (icache_addr),
        .icache_ready    (icache_ready),
        .icache_inst     (icache_inst)
`ifdef IF_PERF_CNT_EN
        ,
        .issue_cnt       (issue_cnt)
`endif
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          lat;
        logic [31:0] nxt;
    } vec_t;

    exp_t        sb[$];
    vec_t        tbl[5];
    int          checks;
    int          errors;
    int          exp_cnt;
    logic [31:0] cur;

    localparam logic [31:0] MASK = 32'hFFFF_FFFC;

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Serve one fetch for addr after lat wait cycles, then check the presented word.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int lat);
        int   n;
        exp_t e;
        n = 0;
        while (icache_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("req_up", {31'd0, icache_req}, 32'd1);
        chk("req_addr", icache_addr, addr & MASK);
        for (int i = 0; i < lat; i++) begin
            tick();
            chk("req_held", {31'd0, icache_req}, 32'd1);
            chk("addr_held", icache_addr, addr & MASK);
            chk("no_valid_fetch", {31'd0, valid}, 32'd0);
        end
        icache_ready = 1'b1;
        icache_inst  = data;
        e.inst = data;
        e.addr = addr;
        sb.push_back(e);
        tick();
        icache_ready = 1'b0;
        icache_inst  = $urandom;
        chk("latency", {31'd0, valid}, 32'd1);
        n = 0;
        while (valid !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("inst", inst, e.inst);
            chk("inst_addr", inst_addr, e.addr);
            chk("start_decoder", {31'd0, start_decoder}, 32'd1);
            chk("req_low_hold", {31'd0, icache_req}, 32'd0);
        end
    endtask

    // Decoder accepts the held instruction and steers to nxt.
    task automatic issue(input logic [31:0] nxt);
        issue_signal = 1'b1;
        next_pc      = nxt;
        tick();
        issue_signal = 1'b0;
        exp_cnt++;
        chk("issue_valid", {31'd0, valid}, 32'd0);
        chk("issue_req", {31'd0, icache_req}, 32'd1);
        chk("issue_addr", icache_addr, nxt & MASK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{addr: 32'h0000_0000, data: 32'h0050_0093, lat: 3, nxt: 32'h0000_0004};
        tbl[1] = '{addr: 32'h0000_0004, data: 32'h0010_0113, lat: 0, nxt: 32'h0000_0008};
        tbl[2] = '{addr: 32'h0000_0008, data: 32'h0020_0193, lat: 1, nxt: 32'h0000_0103};
        tbl[3] = '{addr: 32'h0000_0103, data: 32'hFFFF_FFFF, lat: 2, nxt: 32'h0000_0020};
        tbl[4] = '{addr: 32'h0000_0020, data: 32'h0000_0067, lat: 1, nxt: 32'h0000_0000};

        checks          = 0;
        errors          = 0;
        exp_cnt         = 0;
        rst_in          = 1'b0;
        rdy_in          = 1'b1;
        next_pc         = 32'd0;
        issue_signal    = 1'b0;
        jalr_stall      = 1'b0;
        wrong_predicted = 1'b0;
        correct_pc      = 32'd0;
        icache_ready    = 1'b0;
        icache_inst     = 32'd0;

        tick();
        tick();
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_start", {31'd0, start_decoder}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_addr", inst_addr, 32'd0);
        chk("rst_req", {31'd0, icache_req}, 32'd1);
        chk("rst_addr", icache_addr, 32'd0);
`ifdef IF_PERF_CNT_EN
        chk("rst_cnt", issue_cnt, 32'd0);
`endif
        rst_in = 1'b1;
        tick();

        // Fetch/issue chain; the last entry is held through a JALR stall.
        for (int i = 0; i < 5; i++) begin
            fetch(tbl[i].addr, tbl[i].data, tbl[i].lat);
            if (i < 4) issue(tbl[i].nxt);
        end

        // JALR stall with stray icache_ready pulses that must be ignored.
        jalr_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            icache_ready = i[0];
            icache_inst  = 32'hBAD0_0000 + i;
            tick();
            chk("stall_valid", {31'd0, valid}, 32'd1);
            chk("stall_inst", inst, 32'h0000_0067);
            chk("stall_inst_addr", inst_addr, 32'h0000_0020);
            chk("stall_req", {31'd0, icache_req}, 32'd0);
        end
        icache_ready = 1'b0;
        jalr_stall   = 1'b0;
        issue(32'h0000_0100);
        fetch(32'h0000_0100, 32'h1234_5678, 0);
        issue(32'h0000_0008);

        // Redirect while the request to 0x8 is outstanding.
        tick();
        wrong_predicted = 1'b1;
        correct_pc      = 32'h0000_0040;
        tick();
        wrong_predicted = 1'b0;
        chk("flush_addr", icache_addr, 32'h0000_0008);
        chk("flush_req", {31'd0, icache_req}, 32'd1);
        chk("flush_valid", {31'd0, valid}, 32'd0);
        tick();
        icache_ready = 1'b1;
        icache_inst  = 32'hDEAD_BEEF;
        tick();
        icache_ready = 1'b0;
        chk("drop_valid", {31'd0, valid}, 32'd0);
        chk("drop_addr", icache_addr, 32'h0000_0040);
        fetch(32'h0000_0040, 32'h0040_0013, 1);

        // Two redirects during the flush; the later one is fetched.
        issue(32'h0000_0050);
        wrong_predicted = 1'b1;
        correct_pc      = 32'h0000_0060;
        tick();
        correct_pc      = 32'h0000_0070;
        tick();
        wrong_predicted = 1'b0;
        icache_ready    = 1'b1;
        icache_inst     = 32'hDEAD_0050;
        tick();
        icache_ready = 1'b0;
        chk("reflush_valid", {31'd0, valid}, 32'd0);
        chk("reflush_addr", icache_addr, 32'h0000_0070);
        fetch(32'h0000_0070, 32'h0070_0013, 2);

        // Redirect coinciding with the response.
        issue(32'h0000_0090);
        wrong_predicted = 1'b1;
        correct_pc      = 32'h0000_0080;
        icache_ready    = 1'b1;
        icache_inst     = 32'h1111_1111;
        tick();
        wrong_predicted = 1'b0;
        icache_ready    = 1'b0;
        chk("coinc_valid", {31'd0, valid}, 32'd0);
        chk("coinc_addr", icache_addr, 32'h0000_0080);
        fetch(32'h0000_0080, 32'hCAFE_0080, 0);

        // rdy_in low in HOLD freezes everything despite active inputs.
        rdy_in          = 1'b0;
        issue_signal    = 1'b1;
        next_pc         = 32'h0000_0123;
        wrong_predicted = 1'b1;
        correct_pc      = 32'h0000_0456;
        icache_ready    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("frz_valid", {31'd0, valid}, 32'd1);
            chk("frz_inst", inst, 32'hCAFE_0080);
            chk("frz_inst_addr", inst_addr, 32'h0000_0080);
            chk("frz_req", {31'd0, icache_req}, 32'd0);
            chk("frz_addr", icache_addr, 32'h0000_0080);
        end
        rdy_in          = 1'b1;
        issue_signal    = 1'b0;
        wrong_predicted = 1'b0;
        icache_ready    = 1'b0;
        tick();
        chk("unfrz_valid", {31'd0, valid}, 32'd1);

        // Redirect beats issue in HOLD.
        issue_signal    = 1'b1;
        next_pc         = 32'h0000_0200;
        wrong_predicted = 1'b1;
        correct_pc      = 32'h0000_0300;
        tick();
        issue_signal    = 1'b0;
        wrong_predicted = 1'b0;
        chk("prio_valid", {31'd0, valid}, 32'd0);
        chk("prio_addr", icache_addr, 32'h0000_0300);
        fetch(32'h0000_0300, 32'h0300_0013, 1);
        issue(32'h0000_00A0);

        // Reset while the request to 0xA0 is outstanding.
        tick();
        rst_in = 1'b0;
        tick();
        exp_cnt = 0;
        chk("mid_rst_valid", {31'd0, valid}, 32'd0);
        chk("mid_rst_req", {31'd0, icache_req}, 32'd1);
        chk("mid_rst_addr", icache_addr, 32'd0);
        rst_in = 1'b1;
        fetch(32'h0000_0000, 32'h0000_0013, 2);

        // Reset overrides rdy_in=0.
        rdy_in = 1'b0;
        rst_in = 1'b0;
        tick();
        chk("rst_rdy_valid", {31'd0, valid}, 32'd0);
        chk("rst_rdy_inst", inst, 32'd0);
        chk("rst_rdy_inst_addr", inst_addr, 32'd0);
        rdy_in = 1'b1;
        rst_in = 1'b1;

        // Ten issues, one of them squashed by a coincident redirect.
        cur = 32'd0;
        for (int i = 0; i < 10; i++) begin
            fetch(cur, 32'h0000_0013 + (i << 7), i % 3);
            if (i == 4) begin
                issue_signal    = 1'b1;
                next_pc         = cur + 32'd4;
                wrong_predicted = 1'b1;
                correct_pc      = 32'h0000_0400;
                tick();
                issue_signal    = 1'b0;
                wrong_predicted = 1'b0;
                chk("cnt_flush_addr", icache_addr, 32'h0000_0400);
                cur = 32'h0000_0400;
            end else begin
                issue(cur + 32'd4);
                cur = cur + 32'd4;
            end
        end
        chk("issue_total_model", exp_cnt, 32'd9);
`ifdef IF_PERF_CNT_EN
        chk("issue_cnt", issue_cnt, exp_cnt);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
